// File: rtl/axis_noc_pkg.sv
// Shared NoC stream helpers: TDATA field split {send_ts, seq} and the counter type.
package axis_noc_pkg;

    localparam int MAX_TDATA_WIDTH = 128;
    localparam int DEF_COUNT_WIDTH = 32;
    localparam int SEQ_LO          = 0;

    typedef logic [MAX_TDATA_WIDTH-1:0] tdata_max_t;
    typedef logic [DEF_COUNT_WIDTH-1:0] count_t;

    // Top bit of the timestamp field for a given TDATA width.
    function automatic int ts_hi(input int w);
        return w - 1;
    endfunction

    // Low half of TDATA, zero-extended to the maximum width.
    function automatic tdata_max_t seq_of(input tdata_max_t d, input int w);
        tdata_max_t m;
        m = (tdata_max_t'(1) << (w / 2)) - tdata_max_t'(1);
        return (d >> SEQ_LO) & m;
    endfunction

    // High half of TDATA, zero-extended to the maximum width.
    function automatic tdata_max_t ts_of(input tdata_max_t d, input int w);
        tdata_max_t m;
        m = (tdata_max_t'(1) << (ts_hi(w) + 1 - w / 2)) - tdata_max_t'(1);
        return (d >> (w / 2)) & m;
    endfunction

endpackage

// File: rtl/axis_latency_acc.sv
// Running sum and maximum of per-packet latency; only built with AXIS_CHECKER_LATENCY_EN.
module axis_latency_acc #(
    parameter int LAT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic [63:0]      sum_o,
    output logic [LAT_W-1:0] max_o
);

    logic [63:0]      sum_q, sum_d;
    logic [LAT_W-1:0] max_q, max_d;

    always_comb begin
        sum_d = sum_q;
        max_d = max_q;
        if (en_i) begin
            sum_d = sum_q + 64'(lat_i);
            if (lat_i > max_q) max_d = lat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
            max_q <= '0;
        end else begin
            sum_q <= sum_d;
            max_q <= max_d;
        end
    end

    assign sum_o = sum_q;
    assign max_o = max_q;

endmodule

// File: rtl/axis_stream_checker.sv
// AXI-Stream egress checker: per-source/total packet counts and a sticky routing/order error.
// Optional latency statistics are enabled with `define AXIS_CHECKER_LATENCY_EN.
module axis_stream_checker
    import axis_noc_pkg::*;
#(
    parameter int COUNT_WIDTH = 32,
    parameter int TDEST       = 0,
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 4,
    parameter int TID_WIDTH   = 4,
    parameter int NUM_ROUTERS = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [TDATA_WIDTH/2-1:0]                ticks,
    output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] recv_packets,
    output logic [COUNT_WIDTH-1:0]                  total_recv_packets,
    output logic                                    error,
`ifdef AXIS_CHECKER_LATENCY_EN
    output logic [63:0]                             latency_sum,
    output logic [TDATA_WIDTH/2-1:0]                latency_max,
`endif
    input  logic                                    axis_in_tvalid,
    output logic                                    axis_in_tready,
    input  logic [TDATA_WIDTH-1:0]                  axis_in_tdata,
    input  logic                                    axis_in_tlast,
    input  logic [TID_WIDTH-1:0]                    axis_in_tid,
    input  logic [TDEST_WIDTH-1:0]                  axis_in_tdest
);

    localparam int HALF  = TDATA_WIDTH / 2;
    localparam int CMP_W = (COUNT_WIDTH < HALF) ? COUNT_WIDTH : HALF;
    localparam logic [TID_WIDTH:0] NR_LIM = (TID_WIDTH + 1)'(NUM_ROUTERS);

    logic                                    tready_q;
    logic                                    err_q, err_d;
    logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] recv_q, recv_d;
    logic [COUNT_WIDTH-1:0]                  total_q, total_d;

    tdata_max_t td_ext, seq_full, ts_full;
    logic       acc, pkt, tid_ok, tdest_bad, seq_bad;

    assign td_ext    = tdata_max_t'(axis_in_tdata);
    assign seq_full  = seq_of(td_ext, TDATA_WIDTH);
    assign ts_full   = ts_of(td_ext, TDATA_WIDTH);
    assign acc       = axis_in_tvalid & tready_q;
    assign pkt       = acc & axis_in_tlast;
    assign tid_ok    = {1'b0, axis_in_tid} < NR_LIM;
    assign tdest_bad = axis_in_tdest != TDEST_WIDTH'(TDEST);

    // Sequence numbers are checked against the flow's count before this packet.
    always_comb begin
        recv_d  = recv_q;
        total_d = total_q;
        seq_bad = 1'b0;
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            if (pkt && tid_ok && axis_in_tid == TID_WIDTH'(i)) begin
                seq_bad   = seq_full[CMP_W-1:0] != recv_q[i][CMP_W-1:0];
                recv_d[i] = recv_q[i] + COUNT_WIDTH'(1);
            end
        end
        if (pkt) total_d = total_q + COUNT_WIDTH'(1);
        err_d = err_q | (acc & (~axis_in_tlast | ~tid_ok | tdest_bad | seq_bad));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tready_q <= 1'b0;
            err_q    <= 1'b0;
            recv_q   <= '0;
            total_q  <= '0;
        end else begin
            tready_q <= 1'b1;
            err_q    <= err_d;
            recv_q   <= recv_d;
            total_q  <= total_d;
        end
    end

    assign axis_in_tready     = tready_q;
    assign recv_packets       = recv_q;
    assign total_recv_packets = total_q;
    assign error              = err_q;

`ifdef AXIS_CHECKER_LATENCY_EN
    logic [HALF-1:0] lat;
    assign lat = ticks - ts_full[HALF-1:0];

    axis_latency_acc #(.LAT_W(HALF)) u_lat (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (pkt),
        .lat_i (lat),
        .sum_o (latency_sum),
        .max_o (latency_max)
    );
`endif

    logic unused_bits;
    assign unused_bits = ^{seq_full, ts_full, ticks};

endmodule

// File: tb/tb_axis_stream_checker.sv
// Scoreboard bench for axis_stream_checker (COUNT_WIDTH=4 to exercise counter/sequence wrap).
module tb_axis_stream_checker;

    localparam int CW = 4, DW = 64, HW = 32, TW = 5, DSTW = 4, NR = 16, DST = 5;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [HW-1:0]          ticks = '0;
    logic [NR-1:0][CW-1:0]  recv_packets;
    logic [CW-1:0]          total_recv_packets;
    logic                   error;
    logic                   axis_in_tvalid = 1'b0;
    logic                   axis_in_tready;
    logic [DW-1:0]          axis_in_tdata = '0;
    logic                   axis_in_tlast = 1'b0;
    logic [TW-1:0]          axis_in_tid = '0;
    logic [DSTW-1:0]        axis_in_tdest = '0;
`ifdef AXIS_CHECKER_LATENCY_EN
    logic [63:0]            latency_sum;
    logic [HW-1:0]          latency_max;
`endif

    always #5 clk = ~clk;

    axis_stream_checker #(
        .COUNT_WIDTH(CW), .TDEST(DST), .TDATA_WIDTH(DW),
        .TDEST_WIDTH(DSTW), .TID_WIDTH(TW), .NUM_ROUTERS(NR)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ticks              (ticks),
        .recv_packets       (recv_packets),
        .total_recv_packets (total_recv_packets),
        .error              (error),
`ifdef AXIS_CHECKER_LATENCY_EN
        .latency_sum        (latency_sum),
        .latency_max        (latency_max),
`endif
        .axis_in_tvalid     (axis_in_tvalid),
        .axis_in_tready     (axis_in_tready),
        .axis_in_tdata      (axis_in_tdata),
        .axis_in_tlast      (axis_in_tlast),
        .axis_in_tid        (axis_in_tid),
        .axis_in_tdest      (axis_in_tdest)
    );

    typedef struct {
        logic [NR-1:0][CW-1:0] recv;
        logic [CW-1:0]         total;
        logic                  err;
        logic [63:0]           lsum;
        logic [HW-1:0]         lmax;
    } exp_t;

    exp_t                  sb_q[$];
    int                    checks = 0, failures = 0;
    logic [NR-1:0][CW-1:0] m_recv = '0;
    logic [CW-1:0]         m_total = '0;
    logic                  m_err = 1'b0;
    logic [63:0]           m_lsum = '0;
    logic [HW-1:0]         m_lmax = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic push();
        exp_t e;
        e.recv = m_recv; e.total = m_total; e.err = m_err;
        e.lsum = m_lsum; e.lmax = m_lmax;
        sb_q.push_back(e);
    endtask

    task automatic model_clear();
        m_recv = '0; m_total = '0; m_err = 1'b0; m_lsum = '0; m_lmax = '0;
    endtask

    // Compare registered outputs 1 ns after each edge against what that edge should produce.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("recv", 64'(recv_packets), 64'(e.recv));
                chk("total", 64'(total_recv_packets), 64'(e.total));
                chk("error", 64'(error), 64'(e.err));
`ifdef AXIS_CHECKER_LATENCY_EN
                chk("lat_sum", latency_sum, e.lsum);
                chk("lat_max", 64'(latency_max), 64'(e.lmax));
`endif
            end
        end
    end

    task automatic send(input int tid, input int dest, input logic [HW-1:0] seq,
                        input logic last, input int lat);
        logic [HW-1:0] ts, lat_u;
        ts    = $urandom;
        lat_u = HW'(lat);
        @(negedge clk);
        axis_in_tvalid = 1'b1;
        axis_in_tid    = TW'(tid);
        axis_in_tdest  = DSTW'(dest);
        axis_in_tlast  = last;
        axis_in_tdata  = {ts, seq};
        ticks          = ts + lat_u;
        @(posedge clk);
        if (!last) m_err = 1'b1;
        else begin
            if (dest != DST) m_err = 1'b1;
            if (tid >= NR) m_err = 1'b1;
            else begin
                if (seq[CW-1:0] != m_recv[tid]) m_err = 1'b1;
                m_recv[tid] = m_recv[tid] + 1'b1;
            end
            m_total = m_total + 1'b1;
            m_lsum  = m_lsum + 64'(lat_u);
            if (lat_u > m_lmax) m_lmax = lat_u;
        end
        push();
    endtask

    // Idle cycles with junk on the data lines: nothing may change.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            axis_in_tvalid = 1'b0;
            axis_in_tdata  = {$urandom, $urandom};
            axis_in_tlast  = 1'b1;
            axis_in_tdest  = DSTW'(DST + 1);
            @(posedge clk);
            push();
        end
    endtask

    task automatic do_reset(input int n, input logic with_beat);
        @(negedge clk);
        rst            = 1'b1;
        axis_in_tvalid = with_beat;
        axis_in_tlast  = 1'b1;
        axis_in_tid    = '0;
        axis_in_tdest  = DSTW'(DST);
        axis_in_tdata  = {32'h0, HW'(m_recv[0])};
        repeat (n) @(posedge clk);
        #1;
        chk("rst_tready", 64'(axis_in_tready), 64'd0);
        chk("rst_total", 64'(total_recv_packets), 64'd0);
        chk("rst_recv", 64'(recv_packets), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        model_clear();
        @(negedge clk);
        rst            = 1'b0;
        axis_in_tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("tready_up", 64'(axis_in_tready), 64'd1);
    endtask

    initial begin
        do_reset(3, 1'b0);

        // In-order traffic from two flows
        for (int i = 0; i < 3; i++) send(2, DST, HW'(i), 1'b1, 3 + i);
        send(7, DST, 0, 1'b1, 40);
        idle(2);

        // Misroute, then error must stay set through good traffic
        do_reset(2, 1'b0);
        send(9, 4, 0, 1'b1, 1);
        for (int i = 0; i < 10; i++) send(1, DST, HW'(i), 1'b1, i);

        // Sequence gap
        do_reset(2, 1'b0);
        send(3, DST, 0, 1'b1, 7);
        send(3, DST, 2, 1'b1, 7);

        // Out-of-range tid, then tlast=0, then multiple violations at once
        do_reset(2, 1'b0);
        send(NR, DST, 0, 1'b1, 9);
        do_reset(2, 1'b0);
        send(4, DST, 0, 1'b0, 9);
        idle(1);
        send(4, DST, 0, 1'b1, 2);
        send(NR + 3, 2, 5, 1'b1, 2);

        // Counter and sequence wrap, then reset mid-burst with a live beat
        do_reset(2, 1'b0);
        for (int i = 0; i < 17; i++) send(0, DST, HW'(i), 1'b1, $urandom_range(0, 1000));
        idle(1);
        send(0, DST, 17, 1'b1, 5);
        send(0, DST, 18, 1'b1, 5);
        do_reset(2, 1'b1);
        idle(1);
        send(0, DST, 0, 1'b1, 1);

        repeat (3) @(posedge clk);
        #2;
        if (sb_q.size() != 0) chk("drain", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
